// File: rtl/secuenciador_contador.sv
// Command sequencer driving a cascaded counter (ENB/MODO/D) and checking its Q feedback against a shadow value.
// Latency: count N -> ENB for N cycles, DONE at +N+1; load -> DONE at +2. Backpressure: CMD_READY only in IDLE.
module secuenciador_contador #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_MODO,
  input  logic [WIDTH-1:0]  CMD_DATO,
  input  logic [STEP_W-1:0] CMD_PASOS,
  input  logic [WIDTH-1:0]  Q,
  input  logic              RCO,
  output logic              ENB,
  output logic [1:0]        MODO,
  output logic [WIDTH-1:0]  D,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [7:0]        RCO_CNT
);

  typedef enum logic [1:0] {IDLE, CARGA, CUENTA, VERIF} estado_t;

  typedef struct packed {
    logic [1:0]       modo;
    logic [WIDTH-1:0] dato;
  } cmd_t;

  estado_t           estado, estado_d;
  cmd_t              cmd, cmd_d;
  logic [STEP_W-1:0] restante, restante_d;
  logic [WIDTH-1:0]  esperado, esperado_d;
  logic [WIDTH-1:0]  d_d;
  logic [1:0]        modo_d;
  logic [7:0]        rco_cnt_d;
  logic              enb_d, ready_d, busy_d, done_d, error_d;
  logic              acepta;

  assign acepta = CMD_VALID && CMD_READY;

  // Outputs are computed for the state being entered so they can be registered.
  always_comb begin
    estado_d   = estado;
    cmd_d      = cmd;
    restante_d = restante;
    esperado_d = esperado;
    enb_d      = 1'b0;
    modo_d     = 2'b00;
    d_d        = '0;
    done_d     = 1'b0;
    error_d    = ERROR;
    rco_cnt_d  = RCO_CNT;

    case (estado)
      IDLE: begin
        if (acepta) begin
          cmd_d      = '{modo: CMD_MODO, dato: CMD_DATO};
          restante_d = CMD_PASOS;
          rco_cnt_d  = '0;
          esperado_d = Q;
          if (CMD_MODO == 2'b11) begin
            estado_d = CARGA;
            enb_d    = 1'b1;
            modo_d   = 2'b11;
            d_d      = CMD_DATO;
          end else if (CMD_PASOS == '0) begin
            done_d = 1'b1;
          end else begin
            estado_d = CUENTA;
            enb_d    = 1'b1;
            modo_d   = CMD_MODO;
          end
        end
      end

      CARGA: begin
        esperado_d = cmd.dato;
        estado_d   = VERIF;
        done_d     = 1'b1;
      end

      CUENTA: begin
        case (cmd.modo)
          2'b00:   esperado_d = esperado + WIDTH'(1);
          2'b01:   esperado_d = esperado - WIDTH'(1);
          default: esperado_d = esperado - WIDTH'(3);
        endcase
        restante_d = restante - STEP_W'(1);
        if (RCO && (RCO_CNT != 8'hFF))
          rco_cnt_d = RCO_CNT + 8'd1;
        if (restante == STEP_W'(1)) begin
          estado_d = VERIF;
          done_d   = 1'b1;
        end else begin
          enb_d  = 1'b1;
          modo_d = cmd.modo;
        end
      end

      VERIF: begin
        if (Q != esperado)
          error_d = 1'b1;
        estado_d = IDLE;
      end

      default: estado_d = IDLE;
    endcase

    ready_d = (estado_d == IDLE);
    busy_d  = (estado_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      estado    <= IDLE;
      cmd       <= '0;
      restante  <= '0;
      esperado  <= '0;
      ENB       <= 1'b0;
      MODO      <= 2'b00;
      D         <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERROR     <= 1'b0;
      RCO_CNT   <= '0;
      CMD_READY <= 1'b1;
    end else begin
      estado    <= estado_d;
      cmd       <= cmd_d;
      restante  <= restante_d;
      esperado  <= esperado_d;
      ENB       <= enb_d;
      MODO      <= modo_d;
      D         <= d_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      ERROR     <= error_d;
      RCO_CNT   <= rco_cnt_d;
      CMD_READY <= ready_d;
    end
  end

endmodule

// File: tb/tb_secuenciador_contador.sv
// Bench for secuenciador_contador: a behavioural 16-bit counter closes the loop, and each command's
// expected final value, enable length, DONE timing, RCO count and sticky error are derived arithmetically.
module tb_secuenciador_contador;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic [1:0]  CMD_MODO = 2'b00;
  logic [15:0] CMD_DATO = 16'h0;
  logic [7:0]  CMD_PASOS = 8'h0;
  logic        CMD_READY, ENB, BUSY, DONE, ERROR;
  logic [1:0]  MODO;
  logic [15:0] D;
  logic [7:0]  RCO_CNT;

  logic [15:0] q = 16'h0;
  logic        stuck = 1'b0;
  logic        rco;

  int vectors = 0;
  int miscompares = 0;
  bit ref_err = 1'b0;

  secuenciador_contador #(.WIDTH(16), .STEP_W(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_MODO(CMD_MODO), .CMD_DATO(CMD_DATO), .CMD_PASOS(CMD_PASOS),
    .Q(q), .RCO(rco),
    .ENB(ENB), .MODO(MODO), .D(D),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .RCO_CNT(RCO_CNT)
  );

  always #5 CLK = ~CLK;

  // Counter being sequenced; 'stuck' freezes it to emulate a broken part.
  assign rco = (q == 16'hFFFF);
  always @(posedge CLK) begin
    if (ENB && !stuck) begin
      case (MODO)
        2'b00:   q <= q + 16'd1;
        2'b01:   q <= q - 16'd1;
        2'b10:   q <= q - 16'd3;
        default: q <= D;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] m, input logic [15:0] dat, input logic [7:0] p);
    logic [15:0] q0, qexp, ideal, v, delta, q_done;
    logic        busy_done;
    int          n_exp, en, done_at, rexp;
    @(negedge CLK);
    q0    = q;
    delta = (m == 2'b00) ? 16'h0001 : (m == 2'b01) ? 16'hFFFF : 16'hFFFD;
    rexp  = 0;
    if (m == 2'b11) begin
      n_exp = 1;
      qexp  = dat;
    end else begin
      n_exp = int'(p);
      v     = q0;
      for (int i = 0; i < int'(p); i++) begin
        if (v == 16'hFFFF) rexp++;
        if (!stuck) v = v + delta;
      end
      qexp  = v;
      ideal = q0 + 16'(p) * delta;
      if (ideal != qexp) ref_err = 1'b1;
      if (rexp > 255) rexp = 255;
    end

    CMD_VALID = 1'b1;
    CMD_MODO  = m;
    CMD_DATO  = dat;
    CMD_PASOS = p;
    chk("ready_before", 32'(CMD_READY), 32'(1));
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_MODO  = 2'($urandom);
    CMD_DATO  = 16'($urandom);
    CMD_PASOS = 8'($urandom);

    en = 0;
    done_at = 0;
    q_done = 16'h0;
    busy_done = 1'b0;
    for (int c = 1; (c <= n_exp + 4) && (done_at == 0); c++) begin
      @(negedge CLK);
      if (ENB) begin
        en++;
        if (en == 1) begin
          chk("modo_while_enb", 32'(MODO), 32'(m));
          chk("d_while_enb", 32'(D), (m == 2'b11) ? 32'(dat) : 32'(0));
        end
      end
      if (DONE) begin
        done_at   = c;
        q_done    = q;
        busy_done = BUSY;
      end
    end
    chk("enb_cycles", en, n_exp);
    chk("done_cycle", done_at, n_exp + 1);
    chk("q_at_done", 32'(q_done), 32'(qexp));
    chk("busy_at_done", 32'(busy_done), 32'(n_exp != 0));

    @(negedge CLK);
    chk("done_single_pulse", 32'(DONE), 32'(0));
    chk("error_flag", 32'(ERROR), 32'(ref_err));
    chk("rco_cnt", 32'(RCO_CNT), rexp);
    chk("ready_after", 32'(CMD_READY), 32'(1));
    chk("enb_idle", 32'(ENB), 32'(0));
  endtask

  initial begin
    logic [15:0] q0;
    int dones;
    logic [1:0]  rm;
    logic [15:0] rd;
    logic [7:0]  rp;

    // Reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_enb", 32'(ENB), 32'(0));
    chk("rst_modo", 32'(MODO), 32'(0));
    chk("rst_d", 32'(D), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));
    chk("rst_done", 32'(DONE), 32'(0));
    chk("rst_error", 32'(ERROR), 32'(0));
    chk("rst_rco_cnt", 32'(RCO_CNT), 32'(0));
    chk("rst_ready", 32'(CMD_READY), 32'(1));
    RESET = 1'b0;

    run_cmd(2'b11, 16'h1234, 8'd0);
    run_cmd(2'b11, 16'hFFFD, 8'd0);
    run_cmd(2'b00, 16'h0000, 8'd5);
    run_cmd(2'b11, 16'h0002, 8'd0);
    run_cmd(2'b10, 16'h0000, 8'd1);
    run_cmd(2'b01, 16'h0000, 8'd2);

    // Stuck counter must raise the sticky error, which survives a good command
    run_cmd(2'b11, 16'h0010, 8'd0);
    stuck = 1'b1;
    run_cmd(2'b00, 16'h0000, 8'd3);
    stuck = 1'b0;
    run_cmd(2'b00, 16'h0000, 8'd2);

    run_cmd(2'b01, 16'h0000, 8'd0);

    // Abort in the second counting cycle
    @(negedge CLK);
    q0 = q;
    CMD_VALID = 1'b1;
    CMD_MODO  = 2'b00;
    CMD_PASOS = 8'd10;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_enb", 32'(ENB), 32'(0));
    chk("abort_modo", 32'(MODO), 32'(0));
    chk("abort_busy", 32'(BUSY), 32'(0));
    chk("abort_ready", 32'(CMD_READY), 32'(1));
    chk("abort_error_cleared", 32'(ERROR), 32'(0));
    ref_err = 1'b0;
    RESET = 1'b0;
    dones = (DONE === 1'b1) ? 1 : 0;
    repeat (5) begin
      @(negedge CLK);
      if (DONE === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_two_steps", 32'(q), 32'(q0 + 16'd2));

    // Randomized commands, some loads parked near the wrap point
    for (int i = 0; i < 40; i++) begin
      rm = 2'($urandom_range(0, 3));
      rd = ($urandom_range(0, 1) == 1) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
      rp = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
      run_cmd(rm, rd, rp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/secuenciador_contador.md
Name: secuenciador_contador

Overview:
Command sequencer directly upstream of the 16-bit cascaded counter. It accepts load/count commands over a valid/ready handshake and drives the counter's ENB, MODO and D inputs for an exact number of cycles. It keeps a shadow model of the expected counter value and checks the counter's Q feedback when each command finishes. It also counts RCO assertions seen during counting.

Parameters:
WIDTH, 16, data width of the counter being driven
STEP_W, 8, width of the step-count field in a command

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  sequencer can accept a command (high only in IDLE)
CMD_MODO  in  2  00 up by 1, 01 down by 1, 10 down by 3, 11 parallel load
CMD_DATO  in  WIDTH  load value, used only when CMD_MODO=11
CMD_PASOS  in  STEP_W  number of enabled count cycles, ignored when CMD_MODO=11
Q  in  WIDTH  counter output, fed back
RCO  in  1  counter ripple-carry output
ENB  out  1  counter enable
MODO  out  2  counter mode
D  out  WIDTH  counter parallel-load data
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse when a command completes
ERROR  out  1  sticky flag for a shadow/Q mismatch
RCO_CNT  out  8  number of RCO-high cycles seen during the current command, saturating

Behaviour:
- All state and outputs are registered. The clock and reset ports are named CLK and RESET; there is one clock, and reset is synchronous and active-high.
- Reset values: state=IDLE, ENB=0, MODO=00, D=0, BUSY=0, DONE=0, ERROR=0, RCO_CNT=0, shadow register esperado=0. CMD_READY=1 in the cycle after reset.
- States: IDLE, CARGA, CUENTA, VERIF.
- Command acceptance happens on the edge where CMD_VALID and CMD_READY are both high. On acceptance:
  - capture mode, data and steps;
  - clear RCO_CNT;
  - set esperado <= Q.
- Transitions out of IDLE:
  - mode 11 -> CARGA;
  - PASOS=0 (any count mode) -> stay in IDLE and pulse DONE in the next cycle; ENB never rises and no check is made;
  - otherwise -> CUENTA.
- CARGA lasts exactly 1 cycle:
  - ENB=1, MODO=11, D=captured data;
  - esperado <= data;
  - next state VERIF.
- CUENTA lasts exactly PASOS cycles:
  - ENB=1, MODO=captured mode, D=0;
  - each cycle, esperado updates modulo 2^WIDTH: +1 for 00, -1 for 01, -3 for 10 (wrap-around is legal, not an error);
  - the remaining-step counter decrements; after the last enabled cycle go to VERIF;
  - RCO_CNT increments on each CUENTA cycle with RCO=1 and saturates at 255.
- VERIF lasts 1 cycle:
  - ENB=0, MODO=00, D=0;
  - compare Q with esperado; on mismatch set ERROR<=1;
  - DONE=1 for this cycle;
  - next state IDLE.
- ENB is high only in CARGA and CUENTA. MODO=00 and D=0 in every other state.
- Timing, with a command accepted at edge k:
  - count command: ENB is high in cycles k+1..k+N and DONE is high in cycle k+N+1;
  - load command: ENB is high in cycle k+1 and DONE is high in cycle k+2.
- Back-to-back commands: CMD_READY is low in VERIF, so the earliest next acceptance is the cycle after DONE.
- ERROR is cleared only by RESET; later successful commands do not clear it.
- RESET asserted mid-command aborts it immediately: outputs take reset values on the next cycle, no DONE is issued, and ERROR is cleared.
- CMD_* inputs are ignored while CMD_READY=0.

Test Plan:
- Bench setup: a behavioural 16-bit counter model with RCO=1 when Q=0xFFFF.
- Load: RESET, then command MODO=11, DATO=0x1234 -> ENB=1, MODO=11, D=0x1234 for 1 cycle; DONE 2 cycles after acceptance; Q=0x1234; ERROR=0.
- Wrap up: load 0xFFFD, then up with PASOS=5 -> Q=0x0002 at VERIF; RCO_CNT=1; ERROR=0; ENB high for exactly 5 cycles.
- Down by 3 with wrap: load 0x0002, then mode 10 with PASOS=1 -> Q=0xFFFF; ERROR=0. A following down-by-1 command with PASOS=2 -> Q=0xFFFD; ERROR=0.
- Fault: model Q held stuck during up with PASOS=3 from 0x0010 -> ERROR=1 in the VERIF cycle. ERROR stays 1 through a subsequent good command and clears only after RESET.
- Zero steps: count command with PASOS=0 -> DONE in the cycle after acceptance, ENB never high, BUSY stays 0.
- Abort: RESET asserted in the 2nd CUENTA cycle of PASOS=10 -> next cycle ENB=0, MODO=00, BUSY=0, CMD_READY=1, no DONE pulse; the model shows only 2 enabled steps.
